// File: rtl/mr_issue_sb.sv
// Issue scoreboard: holds decoded instructions on RAW/WAW hazards, caps in-flight count, drains after a taken branch.
// Zero-cycle pass-through from decode to ALU; dec_ready drops on hazard, full, drain or ALU backpressure.
`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif

module mr_issue_sb #(
    parameter int NREGS        = 32,
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [`REGSEL_BITS-1:0] dec_rs1,
    input  logic [`REGSEL_BITS-1:0] dec_rs2,
    input  logic                    dec_rs1_used,
    input  logic                    dec_rs2_used,
    input  logic [`REGSEL_BITS-1:0] dec_rd,
    output logic                    alu_valid,
    input  logic                    alu_ready,
    input  logic                    ret_valid,
    input  logic [`REGSEL_BITS-1:0] ret_rd,
    input  logic                    br_taken,
    output logic                    draining,
    output logic [31:0]             stall_cycles,
    output logic                    err_underflow
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]                  state;
    logic [NREGS-1:0][CNT_W-1:0] pend;
    logic [CNT_W-1:0]            inflight;
    logic [CNT_W-1:0]            inflight_nxt;
    logic [NREGS-1:0]            pend_inc;
    logic [NREGS-1:0]            pend_dec;
    logic                        hazard;
    logic                        full;
    logic                        ok;
    logic                        fire;
    logic                        ret_ok;
    logic                        underflow;

    always_comb begin
        hazard = (dec_rs1_used && dec_rs1 != '0 && pend[dec_rs1] != '0) ||
                 (dec_rs2_used && dec_rs2 != '0 && pend[dec_rs2] != '0) ||
                 (dec_rd != '0 && pend[dec_rd] != '0);
        full      = (inflight == CNT_W'(MAX_INFLIGHT)) && !ret_valid;
        ok        = (state == ST_RUN) && !hazard && !full && !br_taken;
        alu_valid = dec_valid && ok;
        dec_ready = alu_ready && ok;
        fire      = dec_valid && dec_ready;
        draining  = (state == ST_DRAIN);
    end

    // A retire against an empty counter is an error and must not wrap the counter.
    always_comb begin
        pend_inc = '0;
        pend_dec = '0;
        if (fire && dec_rd != '0)
            pend_inc = NREGS'(1) << dec_rd;
        if (ret_valid && ret_rd != '0 && pend[ret_rd] != '0)
            pend_dec = NREGS'(1) << ret_rd;
        ret_ok    = ret_valid && inflight != '0;
        underflow = ret_valid && (inflight == '0 || (ret_rd != '0 && pend[ret_rd] == '0));
        inflight_nxt = inflight;
        if (fire && !ret_ok)
            inflight_nxt = inflight + 1'b1;
        else if (!fire && ret_ok)
            inflight_nxt = inflight - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend          <= '0;
            inflight      <= '0;
            state         <= ST_RUN;
            stall_cycles  <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (r == 0)
                    pend[r] <= '0;
                else if (pend_inc[r] && !pend_dec[r])
                    pend[r] <= pend[r] + 1'b1;
                else if (pend_dec[r] && !pend_inc[r])
                    pend[r] <= pend[r] - 1'b1;
            end
            inflight <= inflight_nxt;
            if (underflow)
                err_underflow <= 1'b1;
            if (dec_valid && !dec_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            // Leaving DRAIN looks at the post-retire count so issue resumes right after the last retire.
            case (state)
                ST_RUN:   if (br_taken) state <= ST_DRAIN;
                ST_DRAIN: if (!br_taken && inflight_nxt == '0) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end
endmodule
